// File: rtl/i2s_stereo_tx.sv
// I2S master transmitter: pairs alternating L/R samples, buffers pairs in a small FIFO
// and shifts them MSB-first with the one-bclk I2S data delay.
module i2s_stereo_tx #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          overflow
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              parity;     // 0: next accepted sample is left
  logic [DATA_W-1:0] l_latch;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] shreg;
  logic              last_lsb;   // LSB of the word in flight, sent at the next slot start
  pair_t             mem [FIFO_DEPTH];
  pair_t             head;
  logic [AW-1:0]     wr_ptr, rd_ptr;

  logic div_tc, fall, slot_start, left_start, push_req, pop, push;

  always_comb begin
    div_tc     = (div_cnt == DW'(BCLK_DIV - 1));
    fall       = div_tc && i2s_bclk;
    slot_start = fall && (bit_cnt == BW'(SLOT_W - 1));
    left_start = slot_start && i2s_lrclk;
    push_req   = sample_valid && parity;
    pop        = left_start && (fifo_level != '0);
    // a pop in the same cycle frees the slot the push needs
    push       = push_req && ((fifo_level != LW'(FIFO_DEPTH)) || pop);
    head       = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {l_latch, sample_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b1;
      i2s_sdata  <= 1'b0;
      bit_cnt    <= BW'(SLOT_W - 1);
      parity     <= 1'b0;
      l_latch    <= '0;
      r_hold     <= '0;
      shreg      <= '0;
      last_lsb   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      overflow <= 1'b0;
      div_cnt  <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) i2s_bclk <= ~i2s_bclk;

      if (sample_valid) begin
        parity <= ~parity;
        if (!parity)   l_latch  <= sample_in;
        else if (!push) overflow <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      if (fall) begin
        bit_cnt <= slot_start ? '0 : bit_cnt + 1'b1;
        if (slot_start) begin
          i2s_lrclk <= ~i2s_lrclk;
          i2s_sdata <= (SLOT_W == DATA_W) ? last_lsb : 1'b0;
          if (!i2s_lrclk) begin
            shreg    <= r_hold;
            last_lsb <= r_hold[0];
          end else if (pop) begin
            shreg    <= head.l;
            r_hold   <= head.r;
            last_lsb <= head.l[0];
          end else begin
            shreg    <= '0;
            r_hold   <= '0;
            last_lsb <= 1'b0;
            underrun <= 1'b1;
          end
        end else begin
          // shifting zeros in makes bits beyond DATA_W come out as 0
          i2s_sdata <= shreg[DATA_W-1];
          shreg     <= shreg << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx (BCLK_DIV=2): decodes the serial stream like an I2S
// receiver sampling on bclk rise and compares against hand-chosen sample pairs.
module tb_i2s_stereo_tx;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [2:0]    fifo_level;
  logic          underrun, overflow;

  i2s_stereo_tx #(.DATA_W(16), .SLOT_W(16), .BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  localparam logic [DW-1:0] BURST [10] = '{16'h8001, 16'h7FFE, 16'hF00F, 16'h0FF0, 16'hAAAA,
                                           16'h5555, 16'h1357, 16'h2468, 16'hDEAD, 16'hBEEF};

  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, lr_gap = 0, last_tog = 0, n_under = 0, n_over = 0;
  logic       prev_bclk = 1'b0, prev_lr = 1'b1, lr_fell = 1'b0, sd_or = 1'b0;
  logic [1:0] rx_q [$];   // {lrclk, sdata} at each bclk rise

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (!prev_bclk && i2s_bclk) rx_q.push_back({i2s_lrclk, i2s_sdata});
    lr_fell = prev_lr && !i2s_lrclk;
    if (i2s_lrclk != prev_lr) begin
      lr_gap   = cyc - last_tog;
      last_tog = cyc;
    end
    n_under += int'(underrun);
    n_over  += int'(overflow);
    sd_or    = sd_or | i2s_sdata;
    prev_bclk = i2s_bclk;
    prev_lr   = i2s_lrclk;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_left_start();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!lr_fell && n < 300);
    check("left_start_seen", {31'b0, lr_fell}, 32'd1);
  endtask

  // word sent in the slot whose start-sample is rx_q[j]: bits at j+1..j+15, LSB at j+16
  function automatic logic [15:0] word_at(input int j);
    logic [15:0] w = 'x;
    if (j + 16 < rx_q.size())
      for (int b = 0; b < 16; b++) w[15-b] = rx_q[j+1+b][0];
    return w;
  endfunction

  task automatic check_frame(input string tag, input int f, input logic [15:0] l, input logic [15:0] r);
    check({tag, "_L"}, {16'b0, word_at(32*f)}, {16'b0, l});
    check({tag, "_R"}, {16'b0, word_at(32*f + 16)}, {16'b0, r});
  endtask

  task automatic send(input logic [DW-1:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    // 1: reset values and clock generation
    run(3);
    check("rst_bclk", {31'b0, i2s_bclk}, 32'd0);
    check("rst_lrclk", {31'b0, i2s_lrclk}, 32'd1);
    check("rst_sdata", {31'b0, i2s_sdata}, 32'd0);
    check("rst_level", {29'b0, fifo_level}, 32'd0);
    check("rst_underrun", {31'b0, underrun}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);

    // 2: pair written before the first slot
    reset = 1'b0; sample_valid = 1'b1; sample_in = 16'hA5C3;
    tick();
    check("bclk_e1", {31'b0, i2s_bclk}, 32'd0);
    sample_in = 16'h1234;
    tick();
    sample_valid = 1'b0;
    check("bclk_e2", {31'b0, i2s_bclk}, 32'd1);
    check("level_one_pair", {29'b0, fifo_level}, 32'd1);
    tick();
    check("bclk_e3", {31'b0, i2s_bclk}, 32'd1);
    tick();
    check("bclk_e4_fall", {31'b0, i2s_bclk}, 32'd0);
    check("first_fall_left", {31'b0, i2s_lrclk}, 32'd0);
    check("popped_level", {29'b0, fifo_level}, 32'd0);
    check("no_underrun_first", {31'b0, underrun}, 32'd0);
    rx_q.delete();
    run(130);
    check("lrclk_period", lr_gap, 32'd64);
    check_frame("pair_a5c3", 0, 16'hA5C3, 16'h1234);
    check("right_bit0", {31'b0, rx_q[16][0]}, 32'd1);
    check("right_lr", {31'b0, rx_q[16][1]}, 32'd1);
    check("next_left_bit0", {31'b0, rx_q[32][0]}, 32'd0);
    check("next_left_lr", {31'b0, rx_q[32][1]}, 32'd0);

    // 3: idle for three frames
    n_under = 0; sd_or = 1'b0;
    run(384);
    check("idle_sdata", {31'b0, sd_or}, 32'd0);
    check("idle_underruns", n_under, 32'd3);
    check("idle_level", {29'b0, fifo_level}, 32'd0);

    // 4: ten-sample burst just after a left-slot start
    wait_left_start();
    n_over = 0;
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample_in = BURST[i];
      tick();
      if (i == 9) check("ovf_pulse", {31'b0, overflow}, 32'd1);
      else        check("ovf_quiet", {31'b0, overflow}, 32'd0);
    end
    sample_valid = 1'b0;
    check("burst_level", {29'b0, fifo_level}, 32'd4);
    tick();
    check("ovf_one_cycle", {31'b0, overflow}, 32'd0);
    check("ovf_count", n_over, 32'd1);
    wait_left_start();
    check("after_pop_level", {29'b0, fifo_level}, 32'd3);
    rx_q.delete(); n_under = 0;
    run(642);
    check_frame("burst_p1", 0, 16'h8001, 16'h7FFE);
    check_frame("burst_p2", 1, 16'hF00F, 16'h0FF0);
    check_frame("burst_p3", 2, 16'hAAAA, 16'h5555);
    check_frame("burst_p4", 3, 16'h1357, 16'h2468);
    check_frame("burst_p5_dropped", 4, 16'h0000, 16'h0000);
    check("burst_underruns", n_under, 32'd2);

    // 5: push and pop on the same left-slot-start cycle
    wait_left_start();
    sample_valid = 1'b1; sample_in = 16'h8421; tick();
    sample_in = 16'h4812; tick();
    sample_in = 16'hC001; tick();
    sample_valid = 1'b0;
    run(124);
    check("pre_coincide_level", {29'b0, fifo_level}, 32'd1);
    n_under = 0; n_over = 0;
    sample_valid = 1'b1; sample_in = 16'h3FFE;
    tick();
    sample_valid = 1'b0;
    check("coincide_left_start", {31'b0, lr_fell}, 32'd1);
    check("coincide_level", {29'b0, fifo_level}, 32'd1);
    check("coincide_underrun", n_under, 32'd0);
    check("coincide_overflow", n_over, 32'd0);
    rx_q.delete();
    run(258);
    check_frame("coincide_a", 0, 16'h8421, 16'h4812);
    check_frame("coincide_b", 1, 16'hC001, 16'h3FFE);

    // 6: reset in the middle of a right slot with a pair queued and a left sample latched
    send(16'h1111); send(16'h2222); send(16'h3333);
    run(80);
    check("mid_right_lr", {31'b0, i2s_lrclk}, 32'd1);
    check("mid_right_level", {29'b0, fifo_level}, 32'd1);
    reset = 1'b1;
    tick();
    check("mrst_bclk", {31'b0, i2s_bclk}, 32'd0);
    check("mrst_lrclk", {31'b0, i2s_lrclk}, 32'd1);
    check("mrst_sdata", {31'b0, i2s_sdata}, 32'd0);
    check("mrst_level", {29'b0, fifo_level}, 32'd0);
    tick();
    reset = 1'b0;
    send(16'h6B2D);
    check("post_rst_left", {29'b0, fifo_level}, 32'd0);
    send(16'h94D3);
    check("post_rst_pair", {29'b0, fifo_level}, 32'd1);
    run(2);
    check("post_rst_first_fall", {31'b0, lr_fell}, 32'd1);
    rx_q.delete();
    run(130);
    check_frame("post_rst_frame", 0, 16'h6B2D, 16'h94D3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
